layer_sequencer: RTL and testbench

- Controller that runs one fully-connected layer on a single shared neuron MAC unit, one output neuron at a time.
- Per neuron: fetches that neuron's weight row from weight memory, hands input_number/inputs/weights to the MAC over valid/ready, then collects neuron_sum and overflow into a layer result buffer.
- Presents the whole layer result upstream with a valid/ready handshake.
- Sits between the layer/network control logic and the neuron MAC unit.

---
 rtl/layer_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Runs one fully-connected layer on a single shared MAC, one output neuron at a time:
// fetch weight row, issue operands over valid/ready, collect the sum into the layer buffer.
module layer_sequencer #(
    parameter int NEURON_NUM          = 5,
    parameter int NEURON_OUTPUT_WIDTH = 10,
    parameter int ACTIVATION_WIDTH    = 9,
    parameter int WEIGHT_CELL_WIDTH   = 16,
    localparam int L = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [L:0]                                layer_size,
    input  logic [L:0]                                input_number,
    input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]    layer_inputs,
    input  logic                                      start_valid,
    output logic                                      start_ready,
    output logic [L-1:0]                              weight_addr,
    input  logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]   weight_data,
    output logic [L:0]                                n_input_number,
    output logic                                      n_input_number_valid,
    input  logic                                      n_input_number_ready,
    output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]    n_inputs,
    output logic                                      n_inputs_valid,
    input  logic                                      n_inputs_ready,
    output logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]   n_weights,
    output logic                                      n_weights_valid,
    input  logic                                      n_weights_ready,
    input  logic [NEURON_OUTPUT_WIDTH-1:0]            n_sum,
    input  logic                                      n_overflow,
    input  logic                                      n_sum_valid,
    output logic                                      n_sum_ready,
    output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] layer_sums,
    output logic [NEURON_NUM-1:0]                     layer_overflow,
    output logic                                      layer_valid,
    input  logic                                      layer_ready
);

    localparam logic [L:0]   MAX_COUNT = (L+1)'(NEURON_NUM);
    localparam logic [L:0]   COUNT_ONE = (L+1)'(1);
    localparam logic [L-1:0] INDEX_ONE = L'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        ISSUE   = 3'd2,
        COLLECT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                                    state_r;
    state_t                                    state_next_s;
    logic [L-1:0]                              index_r;
    logic [L-1:0]                              weight_addr_r;
    logic [L:0]                                size_r;
    logic [L:0]                                number_r;
    logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]    inputs_r;
    logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]   weights_r;
    logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] sums_r;
    logic [NEURON_NUM-1:0]                     ovf_r;
    logic                                      num_valid_r;
    logic                                      inp_valid_r;
    logic                                      wgt_valid_r;
    logic                                      start_ready_r;
    logic                                      sum_ready_r;
    logic                                      layer_valid_r;
    logic [L:0]                                size_clamped_s;
    logic [L:0]                                number_clamped_s;
    logic                                      last_s;
    logic                                      all_accepted_s;

    function automatic logic [L:0] clamp_count(input logic [L:0] value);
        if (value > MAX_COUNT) begin
            return MAX_COUNT;
        end else begin
            return value;
        end
    endfunction

    // Clamped configuration, last-neuron detect and issue-completion detect
    always_comb begin
        size_clamped_s   = clamp_count(layer_size);
        number_clamped_s = clamp_count(input_number);
        last_s           = ({1'b0, index_r} == (size_r - COUNT_ONE));
        // A channel is finished once its valid is low or is being accepted this cycle
        all_accepted_s   = (!num_valid_r || n_input_number_ready) &&
                           (!inp_valid_r || n_inputs_ready) &&
                           (!wgt_valid_r || n_weights_ready);
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_valid) begin
                    if ((size_clamped_s == '0) || (number_clamped_s == '0)) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = FETCH;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: state_next_s = ISSUE;
            ISSUE: begin
                if (all_accepted_s) begin
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            COLLECT: begin
                if (n_sum_valid) begin
                    if (last_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = FETCH;
                    end
                end else begin
                    state_next_s = COLLECT;
                end
            end
            DONE: begin
                if (layer_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register, registered handshake outputs and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            start_ready_r <= 1'b1;
            sum_ready_r   <= 1'b0;
            layer_valid_r <= 1'b0;
            num_valid_r   <= 1'b0;
            inp_valid_r   <= 1'b0;
            wgt_valid_r   <= 1'b0;
            index_r       <= '0;
            weight_addr_r <= '0;
            size_r        <= '0;
            number_r      <= '0;
            inputs_r      <= '0;
            weights_r     <= '0;
            sums_r        <= '0;
            ovf_r         <= '0;
        end else begin
            state_r       <= state_next_s;
            start_ready_r <= (state_next_s == IDLE);
            sum_ready_r   <= (state_next_s == COLLECT);
            layer_valid_r <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        inputs_r      <= layer_inputs;
                        size_r        <= size_clamped_s;
                        number_r      <= number_clamped_s;
                        sums_r        <= '0;
                        ovf_r         <= '0;
                        index_r       <= '0;
                        weight_addr_r <= '0;
                    end
                end
                FETCH: begin
                    weights_r   <= weight_data;
                    num_valid_r <= 1'b1;
                    inp_valid_r <= 1'b1;
                    wgt_valid_r <= 1'b1;
                end
                ISSUE: begin
                    if (n_input_number_ready) num_valid_r <= 1'b0;
                    if (n_inputs_ready)       inp_valid_r <= 1'b0;
                    if (n_weights_ready)      wgt_valid_r <= 1'b0;
                end
                COLLECT: begin
                    if (n_sum_valid) begin
                        sums_r[index_r*NEURON_OUTPUT_WIDTH +: NEURON_OUTPUT_WIDTH] <= n_sum;
                        ovf_r[index_r] <= n_overflow;
                        if (!last_s) begin
                            index_r       <= index_r + INDEX_ONE;
                            weight_addr_r <= index_r + INDEX_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign start_ready          = start_ready_r;
    assign weight_addr          = weight_addr_r;
    assign n_input_number       = number_r;
    assign n_input_number_valid = num_valid_r;
    assign n_inputs             = inputs_r;
    assign n_inputs_valid       = inp_valid_r;
    assign n_weights            = weights_r;
    assign n_weights_valid      = wgt_valid_r;
    assign n_sum_ready          = sum_ready_r;
    assign layer_sums           = sums_r;
    assign layer_overflow       = ovf_r;
    assign layer_valid          = layer_valid_r;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: behavioural MAC with configurable ready delays,
// weight memory model, and a scoreboard of expected layer results.
module tb_layer_sequencer;

    localparam int NN = 5;
    localparam int OW = 10;
    localparam int AW = 9;
    localparam int WW = 16;
    localparam int L  = 3;

    typedef struct {
        logic [NN*OW-1:0] sums;
        logic [NN-1:0]    ovf;
        int               nfetch;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [L:0]        layer_size = '0;
    logic [L:0]        input_number = '0;
    logic [NN*AW-1:0]  layer_inputs = '0;
    logic              start_valid = 1'b0;
    logic              start_ready;
    logic [L-1:0]      weight_addr;
    logic [NN*WW-1:0]  weight_data;
    logic [L:0]        n_input_number;
    logic              n_input_number_valid, n_input_number_ready;
    logic [NN*AW-1:0]  n_inputs;
    logic              n_inputs_valid, n_inputs_ready;
    logic [NN*WW-1:0]  n_weights;
    logic              n_weights_valid, n_weights_ready;
    logic [OW-1:0]     n_sum = '0;
    logic              n_overflow = 1'b0;
    logic              n_sum_valid = 1'b0;
    logic              n_sum_ready;
    logic [NN*OW-1:0]  layer_sums;
    logic [NN-1:0]     layer_overflow;
    logic              layer_valid;
    logic              layer_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [NN*WW-1:0] wmem [NN];
    exp_t             sb_q [$];
    logic [L-1:0]     addr_q [$];

    int           dly [3] = '{0, 0, 0};
    int           cnt [3] = '{0, 0, 0};
    int           xfer [3] = '{0, 0, 0};
    int           xfer_base [3];
    int           addr_base;
    int           proto_err = 0;
    int           mac_lat = 1;
    int           lat_cnt = 0;
    logic         busy = 1'b0;
    logic [2:0]   hold = '0, acc = '0, got = '0;
    logic [2:0]   vld_s, rdy_s;
    logic [127:0] dat_s [3];
    logic [127:0] prev_dat [3];
    logic [L:0]   cap_num = '0;
    logic [NN*AW-1:0] cap_in = '0;
    logic [NN*WW-1:0] cap_w = '0;

    layer_sequencer dut (
        .clk(clk), .rst(rst), .layer_size(layer_size), .input_number(input_number),
        .layer_inputs(layer_inputs), .start_valid(start_valid), .start_ready(start_ready),
        .weight_addr(weight_addr), .weight_data(weight_data),
        .n_input_number(n_input_number), .n_input_number_valid(n_input_number_valid),
        .n_input_number_ready(n_input_number_ready),
        .n_inputs(n_inputs), .n_inputs_valid(n_inputs_valid), .n_inputs_ready(n_inputs_ready),
        .n_weights(n_weights), .n_weights_valid(n_weights_valid), .n_weights_ready(n_weights_ready),
        .n_sum(n_sum), .n_overflow(n_overflow), .n_sum_valid(n_sum_valid), .n_sum_ready(n_sum_ready),
        .layer_sums(layer_sums), .layer_overflow(layer_overflow), .layer_valid(layer_valid),
        .layer_ready(layer_ready)
    );

    always #5 clk = ~clk;

    assign weight_data = (int'(weight_addr) < NN) ? wmem[weight_addr] : '0;
    assign n_input_number_ready = n_input_number_valid && (cnt[0] >= dly[0]);
    assign n_inputs_ready       = n_inputs_valid && (cnt[1] >= dly[1]);
    assign n_weights_ready      = n_weights_valid && (cnt[2] >= dly[2]);
    assign vld_s    = {n_weights_valid, n_inputs_valid, n_input_number_valid};
    assign rdy_s    = {n_weights_ready, n_inputs_ready, n_input_number_ready};
    assign dat_s[0] = 128'(n_input_number);
    assign dat_s[1] = 128'(n_inputs);
    assign dat_s[2] = 128'(n_weights);

    function automatic logic [OW:0] mac_f(input logic [L:0] num, input logic [NN*AW-1:0] inp,
                                          input logic [NN*WW-1:0] w);
        logic signed [31:0] accum;
        logic               ovf;
        accum = 32'sd0;
        for (int k = 0; k < NN; k++) begin
            if (k < int'(num)) accum += $signed(inp[k*AW +: AW]) * $signed(w[k*WW +: WW]);
        end
        ovf = (accum > 32'sd511) || (accum < -32'sd512);
        return {ovf, accum[OW-1:0]};
    endfunction

    // Behavioural MAC: handshake monitor, operand capture and delayed result
    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) cnt[c] <= 0;
            hold <= '0; acc <= '0; got <= '0; busy <= 1'b0; lat_cnt <= 0;
            n_sum_valid <= 1'b0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (acc[c] && vld_s[c]) proto_err++;
                if (hold[c] && (!vld_s[c] || (dat_s[c] !== prev_dat[c]))) proto_err++;
                hold[c]     <= vld_s[c] && !rdy_s[c];
                prev_dat[c] <= dat_s[c];
                acc[c]      <= vld_s[c] && rdy_s[c];
                cnt[c]      <= (vld_s[c] && !rdy_s[c]) ? cnt[c] + 1 : 0;
                if (vld_s[c] && rdy_s[c]) begin
                    xfer[c]++;
                    got[c] <= 1'b1;
                end
            end
            if (n_input_number_valid && n_input_number_ready) cap_num <= n_input_number;
            if (n_inputs_valid && n_inputs_ready) cap_in <= n_inputs;
            if (n_weights_valid && n_weights_ready) begin
                cap_w <= n_weights;
                addr_q.push_back(weight_addr);
            end
            if (n_sum_valid) begin
                if (n_sum_ready) begin
                    n_sum_valid <= 1'b0; got <= '0; busy <= 1'b0;
                end
            end else if (got == 3'b111 && !busy) begin
                busy <= 1'b1; lat_cnt <= mac_lat;
            end else if (busy && lat_cnt > 0) begin
                lat_cnt <= lat_cnt - 1;
            end else if (busy) begin
                {n_overflow, n_sum} <= mac_f(cap_num, cap_in, cap_w);
                n_sum_valid <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [NN*OW-1:0] pack5(input int s0, input int s1, input int s2,
                                              input int s3, input int s4);
        logic [NN*OW-1:0] r;
        r[0*OW +: OW] = OW'(s0); r[1*OW +: OW] = OW'(s1); r[2*OW +: OW] = OW'(s2);
        r[3*OW +: OW] = OW'(s3); r[4*OW +: OW] = OW'(s4);
        return r;
    endfunction

    function automatic exp_t mk(input logic [NN*OW-1:0] s, input logic [NN-1:0] o, input int n);
        exp_t e;
        e.sums = s; e.ovf = o; e.nfetch = n;
        return e;
    endfunction

    task automatic clear_data();
        layer_inputs = '0;
        for (int r = 0; r < NN; r++) wmem[r] = '0;
    endtask

    task automatic set_act(input int k, input int v);
        layer_inputs[k*AW +: AW] = AW'(v);
    endtask

    task automatic set_w(input int r, input int c, input int v);
        wmem[r][c*WW +: WW] = WW'(v);
    endtask

    task automatic load_case_a();
        clear_data();
        set_act(0, 1); set_act(1, 2);
        set_w(0, 0, 3);  set_w(0, 1, 4);
        set_w(1, 0, -1); set_w(1, 1, 1);
        set_w(2, 0, 0);  set_w(2, 1, 5);
    endtask

    task automatic start_layer(input int size, input int num, input exp_t e);
        int n = 0;
        for (int c = 0; c < 3; c++) xfer_base[c] = xfer[c];
        addr_base = addr_q.size();
        layer_size = (L+1)'(size); input_number = (L+1)'(num);
        sb_q.push_back(e);
        @(negedge clk);
        while (!start_ready && n < 50) begin @(negedge clk); n++; end
        check("start_ready_before_start", 64'(start_ready), 64'(1));
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    task automatic finish_layer(input string tag, input int hold_cycles);
        exp_t e;
        int   n = 0;
        while (!layer_valid && n < 2000) begin @(negedge clk); n++; end
        e = sb_q.pop_front();
        if (!layer_valid) begin
            checks++; errors++;
            $error("FAIL %s_timeout observed=0 expected=1", tag);
        end else begin
            check({tag, "_sums"}, 64'(layer_sums), 64'(e.sums));
            check({tag, "_ovf"}, 64'(layer_overflow), 64'(e.ovf));
            check({tag, "_nfetch"}, 64'(addr_q.size() - addr_base), 64'(e.nfetch));
            if (addr_q.size() >= addr_base + e.nfetch) begin
                for (int i = 0; i < e.nfetch; i++)
                    check({tag, "_addr"}, 64'(addr_q[addr_base + i]), 64'(i));
            end
            for (int c = 0; c < 3; c++) check({tag, "_xfer"}, 64'(xfer[c] - xfer_base[c]), 64'(e.nfetch));
            check({tag, "_proto"}, 64'(proto_err), 64'(0));
            for (int i = 0; i < hold_cycles; i++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, 64'(layer_valid), 64'(1));
                check({tag, "_hold_sums"}, 64'(layer_sums), 64'(e.sums));
                check({tag, "_hold_start_ready"}, 64'(start_ready), 64'(0));
            end
            @(negedge clk);
            layer_ready = 1'b1;
            @(posedge clk); #1;
            layer_ready = 1'b0;
            check({tag, "_start_ready_after"}, 64'(start_ready), 64'(1));
            check({tag, "_layer_valid_after"}, 64'(layer_valid), 64'(0));
        end
    endtask

    initial begin
        int n;
        clear_data();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_start_ready", 64'(start_ready), 64'(1));
        check("rst_mac_valids", 64'(vld_s), 64'(0));
        check("rst_sum_ready", 64'(n_sum_ready), 64'(0));
        check("rst_layer_valid", 64'(layer_valid), 64'(0));
        check("rst_layer_sums", 64'(layer_sums), 64'(0));
        check("rst_layer_ovf", 64'(layer_overflow), 64'(0));
        rst = 1'b0;

        // Basic three-neuron layer, result held for 10 cycles
        load_case_a();
        start_layer(3, 2, mk(pack5(11, 1, 10, 0, 0), 5'b00000, 3));
        finish_layer("basic", 10);

        // Staggered MAC readies
        dly[0] = 0; dly[1] = 1; dly[2] = 3;
        start_layer(3, 2, mk(pack5(11, 1, 10, 0, 0), 5'b00000, 3));
        finish_layer("stagger", 0);
        dly[1] = 0; dly[2] = 0;

        // Empty layer: valid one cycle after acceptance
        start_layer(0, 2, mk(pack5(0, 0, 0, 0, 0), 5'b00000, 0));
        check("size0_valid_cycle1", 64'(layer_valid), 64'(1));
        finish_layer("size0", 0);
        start_layer(3, 0, mk(pack5(0, 0, 0, 0, 0), 5'b00000, 0));
        check("num0_valid_cycle1", 64'(layer_valid), 64'(1));
        finish_layer("num0", 0);

        // Oversized config clamps to five neurons / five inputs
        clear_data();
        for (int k = 0; k < NN; k++) begin
            set_act(k, 1);
            for (int c = 0; c < NN; c++) set_w(k, c, k + 1);
        end
        start_layer(7, 7, mk(pack5(5, 10, 15, 20, 25), 5'b00000, 5));
        finish_layer("clamp", 0);
        check("clamp_mac_num", 64'(cap_num), 64'(5));

        // Overflow flag lands in the right bit
        clear_data();
        set_act(0, 200); set_w(0, 0, 10); set_w(1, 0, 2);
        start_layer(2, 1, mk(pack5(976, 400, 0, 0, 0), 5'b00001, 2));
        finish_layer("ovf", 0);

        // Reset during collect of neuron 1, then a fresh layer
        load_case_a();
        mac_lat = 4;
        start_layer(3, 2, mk(pack5(11, 1, 10, 0, 0), 5'b00000, 3));
        n = 0;
        while (!(n_sum_ready && weight_addr == 3'd1) && n < 200) begin @(negedge clk); n++; end
        check("reset_reached_collect1", 64'(n_sum_ready && weight_addr == 3'd1), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb_q.pop_front());
        check("midrst_start_ready", 64'(start_ready), 64'(1));
        check("midrst_sums", 64'(layer_sums), 64'(0));
        check("midrst_ovf", 64'(layer_overflow), 64'(0));
        check("midrst_valids", 64'({vld_s, n_sum_ready, layer_valid}), 64'(0));
        check("midrst_addr", 64'(weight_addr), 64'(0));
        mac_lat = 1;
        start_layer(3, 2, mk(pack5(11, 1, 10, 0, 0), 5'b00000, 3));
        finish_layer("after_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
